uwasic_onboarding_justin_leong: RTL and testbench
=================================================

Name: uwasic_onboarding_justin_leong

Overview:
- Tiny Tapeout user-project top: write-only SPI peripheral feeding a five-entry register file, driving 16 outputs.
- Each output is forced low, forced high, or driven by one shared ~3 kHz PWM signal.
- Sits directly under the TT harness; sole chip-level block of the onboarding project.

Parameters:
- CLK_DIV, 13, prescaler divide ratio; PWM tick = clk/CLK_DIV (10 MHz -> ~769 kHz tick, ~3.0 kHz period).
- NUM_REGS, 5, number of writable registers (addresses 0x00..NUM_REGS-1).

Ports:
- clk  in  1  system clock, 10 MHz nominal.
- rst_n  in  1  reset; one clock, reset is synchronous and active-low.
- ena  in  1  harness select; ignored.
- ui_in  in  8  [0]=SCLK, [1]=COPI, [2]=nCS; [7:3] unused.
- uio_in  in  8  unused.
- uo_out  out  8  output channels 7..0.
- uio_out  out  8  output channels 15..8.
- uio_oe  out  8  constant 8'hFF (all bidirectionals are outputs).

Behaviour:
- Reset: every register = 0x00, SPI shift state cleared; uo_out = uio_out = 0x00; uio_oe = 0xFF always.
- Registers: 0x00 en_out[7:0]; 0x01 en_out[15:8]; 0x02 en_pwm[7:0]; 0x03 en_pwm[15:8]; 0x04 duty[7:0].
- Per channel i: out[i] = en_out[i] ? (en_pwm[i] ? pwm : 1) : 0.
- SPI inputs pass a 2-flop synchronizer; edges detected on synchronized signals.
- SPI mode 0, MSB first. COPI is sampled on each SCLK rising edge while nCS is low.
- Frame is 16 bits: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
- nCS falling edge clears the bit counter and shift register.
- Commit happens on the synchronized nCS rising edge only when all hold:
  - exactly 16 bits were received;
  - R/W = 1;
  - address < NUM_REGS.
- Every other frame is discarded with no state change: reads, out-of-range addresses, short frames, and frames longer than 16 bits.
- Written value appears on outputs no later than 4 clk cycles after the nCS pin rises.
- SCLK high and low phases must each be at least 3 clk cycles; faster SCLK is unsupported.
- PWM: prescaler counts 0..CLK_DIV-1; on wrap, the 8-bit period counter increments (255 wraps to 0).
  - pwm = (counter < duty) when duty != 0xFF; pwm = 1 constantly when duty = 0xFF.
  - Hence duty 0x00 gives constant 0, and duty 0x80 gives 50% high.
- PWM counters run continuously from reset regardless of enables.
- Reset asserted mid-frame aborts the frame; the partial frame is never committed.

Optional Feature:
- PWM_SYNC_UPDATE_EN defined:
  - Duty writes go to a shadow register.
  - The active duty loads from the shadow only when the period counter wraps 255->0, giving glitch-free updates.
  - Reset clears both shadow and active duty.
- PWM_SYNC_UPDATE_EN undefined: the active duty takes the written value immediately on commit.

Decomposition:
- Shared package holds:
  - register address constants (ADDR_EN_OUT_LO..ADDR_DUTY);
  - frame width 16 and address width 7;
  - CLK_DIV default;
  - an enum for SPI frame state (IDLE, SHIFT).
- One natural sub-module, pwm_gen: prescaler, period counter, duty compare and the optional shadow register; outputs the single pwm bit.
- SPI receiver, register file and output mux stay in the top.

Test Plan:
- Reset, then no stimulus -> uo_out = 0x00, uio_out = 0x00, uio_oe = 0xFF.
- Write 0x00 <- 0xF0, then 0x01 <- 0xCC -> uo_out = 0xF0, uio_out = 0xCC within 4 clks of nCS rise.
- Read frame to 0x00 with data 0xFF, and write to 0x30 -> outputs unchanged.
- Write 0x00 <- 0x01, 0x02 <- 0x01, 0x04 <- 0x80 -> uo_out[0] period 256*13 clks ±1, high for 128*13 clks; repeat with duty 0x00 (always 0) and 0xFF (always 1).
- Raise nCS after 15 bits, and separately after 17 bits -> no register change.
- With PWM_SYNC_UPDATE_EN, change duty mid-period -> old duty held until the next counter wrap.

Source files
------------

// File: rtl/uwasic_onboarding_justin_leong_pkg.sv
// Shared constants and types for the SPI-programmed output/PWM peripheral.
package uwasic_onboarding_justin_leong_pkg;

    localparam int unsigned FRAME_W          = 16;
    localparam int unsigned ADDR_W           = 7;
    localparam int unsigned DATA_W           = 8;
    localparam int unsigned CNT_W            = 5;
    localparam int unsigned CLK_DIV_DEFAULT  = 13;
    localparam int unsigned NUM_REGS_DEFAULT = 5;

    localparam int unsigned ADDR_EN_OUT_LO = 0;
    localparam int unsigned ADDR_EN_OUT_HI = 1;
    localparam int unsigned ADDR_EN_PWM_LO = 2;
    localparam int unsigned ADDR_EN_PWM_HI = 3;
    localparam int unsigned ADDR_DUTY      = 4;

    localparam logic [DATA_W-1:0] DUTY_FULL = 8'hFF;

    // Bit counter saturates one past a full frame so over-long frames stay rejected.
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(FRAME_W + 1);

    typedef enum logic {
        StIdle,
        StShift
    } spi_state_e;

    function automatic logic frame_ok(input logic [FRAME_W-1:0] frame,
                                      input logic [CNT_W-1:0]   nbits,
                                      input int unsigned        num_regs);
        logic [ADDR_W-1:0] addr;
        addr = frame[FRAME_W-2 -: ADDR_W];
        return (nbits == CNT_FULL) && frame[FRAME_W-1] && (32'(addr) < num_regs);
    endfunction

endpackage

// File: rtl/uwasic_onboarding_justin_leong_pwm_gen.sv
// Shared PWM source: prescaler, 8-bit period counter and duty compare.
// Optional PWM_SYNC_UPDATE_EN holds new duty values until the period counter wraps.
module uwasic_onboarding_justin_leong_pwm_gen
    import uwasic_onboarding_justin_leong_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] duty,
    output logic              pwm
);

    localparam int unsigned        PRESC_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [DATA_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0]  duty_active;
    logic               tick;

    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + PRESC_W'(1);
        count_d = tick ? count_q + 8'd1 : count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            count_q <= '0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
        end
    end

`ifdef PWM_SYNC_UPDATE_EN
    logic [DATA_W-1:0] duty_q;
    logic              wrap;

    assign wrap = tick && (count_q == 8'hFF);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty_q <= '0;
        end else if (wrap) begin
            duty_q <= duty;
        end
    end

    assign duty_active = duty_q;
`else
    assign duty_active = duty;
`endif

    // Full-scale duty must stay high through count 255, which a plain compare cannot do.
    assign pwm = (duty_active == DUTY_FULL) ? 1'b1 : (count_q < duty_active);

endmodule

// File: rtl/uwasic_onboarding_justin_leong.sv
// Tiny Tapeout top: write-only SPI (mode 0) into a small register file that selects, per
// output, off / on / shared PWM. PWM_SYNC_UPDATE_EN enables period-aligned duty updates.
module uwasic_onboarding_justin_leong
    import uwasic_onboarding_justin_leong_pkg::*;
#(
    parameter int unsigned CLK_DIV  = CLK_DIV_DEFAULT,
    parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
    logic       sclk_prev_q, ncs_prev_q;
    logic       sclk_s, copi_s, ncs_s;
    logic       sclk_rise, ncs_fall, ncs_rise;

    // nCS syncs reset high so a deasserted pin never looks like an edge after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync_q <= 2'b00;
            copi_sync_q <= 2'b00;
            ncs_sync_q  <= 2'b11;
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], ui_in[0]};
            copi_sync_q <= {copi_sync_q[0], ui_in[1]};
            ncs_sync_q  <= {ncs_sync_q[0], ui_in[2]};
            sclk_prev_q <= sclk_sync_q[1];
            ncs_prev_q  <= ncs_sync_q[1];
        end
    end

    assign sclk_s    = sclk_sync_q[1];
    assign copi_s    = copi_sync_q[1];
    assign ncs_s     = ncs_sync_q[1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign ncs_fall  = ~ncs_s & ncs_prev_q;
    assign ncs_rise  = ncs_s & ~ncs_prev_q;

    spi_state_e         state_q, state_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               commit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ncs_fall) begin
                    state_d = StShift;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            StShift: begin
                if (ncs_rise) begin
                    state_d = StIdle;
                    commit  = frame_ok(shift_q, cnt_q, NUM_REGS);
                end else if (sclk_rise && !ncs_s) begin
                    shift_d = {shift_q[FRAME_W-2:0], copi_s};
                    if (cnt_q != CNT_OVER) begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    assign wr_addr = shift_q[FRAME_W-2 -: ADDR_W];
    assign wr_data = shift_q[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (commit && (wr_addr == ADDR_W'(i))) begin
                    regs_q[i] <= wr_data;
                end
            end
        end
    end

    logic [15:0] en_out, en_pwm, chan;
    logic        pwm;

    assign en_out = {regs_q[ADDR_EN_OUT_HI], regs_q[ADDR_EN_OUT_LO]};
    assign en_pwm = {regs_q[ADDR_EN_PWM_HI], regs_q[ADDR_EN_PWM_LO]};

    uwasic_onboarding_justin_leong_pwm_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pwm_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .duty  (regs_q[ADDR_DUTY]),
        .pwm   (pwm)
    );

    assign chan    = en_out & (~en_pwm | {16{pwm}});
    assign uo_out  = chan[7:0];
    assign uio_out = chan[15:8];
    assign uio_oe  = 8'hFF;

    logic unused;
    assign unused = &{1'b0, ena, uio_in, ui_in[7:3]};

endmodule

// File: tb/tb_uwasic_onboarding_justin_leong.sv
// Self-checking bench: SPI frame table with a scoreboard, plus PWM and reset corner cases.
`timescale 1ns/1ps
module tb_uwasic_onboarding_justin_leong;

    localparam int PERIOD = 256 * 13;
    localparam int HIGH50 = 128 * 13;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
    logic [7:0] ui_in, uio_in;
    logic [7:0] uo_out, uio_out, uio_oe;

    assign ui_in  = {5'b0, ncs, copi, sclk};
    assign uio_in = 8'h00;

    uwasic_onboarding_justin_leong dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #50 clk = ~clk;

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
        int         nbits;
        logic [7:0] exp_uo;
        logic [7:0] exp_uio;
    } vec_t;

    typedef struct {
        logic [7:0] uo;
        logic [7:0] uio;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b);
        copi = b;
        wait_clks(4);
        sclk = 1'b1;
        wait_clks(4);
        sclk = 1'b0;
    endtask

    // Sends word[n-1:0] MSB first inside one nCS-low window.
    task automatic spi_send(input logic [31:0] word, input int n);
        @(negedge clk);
        ncs = 1'b0;
        wait_clks(4);
        for (int i = n - 1; i >= 0; i--) spi_bit(word[i]);
        wait_clks(4);
        ncs = 1'b1;
    endtask

    task automatic run_frame(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                             input int nbits);
        logic [31:0] word;
        word = {16'h0, rw, addr, data};
        if (nbits < 16) word = word >> (16 - nbits);
        if (nbits > 16) word = word << (nbits - 16);
        spi_send(word, nbits);
    endtask

    // Outputs must settle within 4 clocks of the nCS pin rising.
    task automatic collect(input string name);
        exp_t e;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            total--;
            check8({name, " uo_out"}, uo_out, e.uo);
            check8({name, " uio_out"}, uio_out, e.uio);
        end
    endtask

    task automatic write_reg(input logic [6:0] addr, input logic [7:0] data);
        run_frame(1'b1, addr, data, 16);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wait_level(input logic lvl, input int limit, output bit ok);
        int n = 0;
        while (uo_out[0] !== lvl && n < limit) begin
            @(negedge clk);
            n++;
        end
        ok = (uo_out[0] === lvl);
    endtask

    task automatic count_level(input logic lvl, input int limit, output int n);
        n = 0;
        while (uo_out[0] === lvl && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic count_ones(input int n, output int ones);
        ones = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (uo_out[0] === 1'b1) ones++;
        end
    endtask

    vec_t vecs[14];

    initial begin
        bit ok;
        int hi, lo, ones;

        vecs[0]  = '{1'b1, 7'h00, 8'hF0, 16, 8'hF0, 8'h00};
        vecs[1]  = '{1'b1, 7'h01, 8'hCC, 16, 8'hF0, 8'hCC};
        vecs[2]  = '{1'b0, 7'h00, 8'hFF, 16, 8'hF0, 8'hCC};  // read: ignored
        vecs[3]  = '{1'b1, 7'h30, 8'hFF, 16, 8'hF0, 8'hCC};  // bad address
        vecs[4]  = '{1'b1, 7'h00, 8'h0F, 15, 8'hF0, 8'hCC};  // short frame
        vecs[5]  = '{1'b1, 7'h00, 8'h0F, 17, 8'hF0, 8'hCC};  // long frame
        vecs[6]  = '{1'b1, 7'h05, 8'hFF, 16, 8'hF0, 8'hCC};  // first invalid address
        vecs[7]  = '{1'b1, 7'h00, 8'h5A, 16, 8'h5A, 8'hCC};
        vecs[8]  = '{1'b1, 7'h01, 8'hFF, 16, 8'h5A, 8'hFF};
        vecs[9]  = '{1'b1, 7'h03, 8'h0F, 16, 8'h5A, 8'hF0};  // pwm on, duty 0 -> low
        vecs[10] = '{1'b1, 7'h02, 8'hFF, 16, 8'h00, 8'hF0};
        vecs[11] = '{1'b1, 7'h02, 8'h00, 16, 8'h5A, 8'hF0};
        vecs[12] = '{1'b1, 7'h03, 8'h00, 16, 8'h5A, 8'hFF};
        vecs[13] = '{1'b1, 7'h04, 8'h07, 16, 8'h5A, 8'hFF};

        wait_clks(5);
        check8("oe in reset", uio_oe, 8'hFF);
        rst_n = 1'b1;
        wait_clks(10);
        check8("reset uo_out", uo_out, 8'h00);
        check8("reset uio_out", uio_out, 8'h00);
        check8("reset uio_oe", uio_oe, 8'hFF);

        // Reset in the middle of a valid write frame must drop the frame.
        @(negedge clk);
        ncs = 1'b0;
        wait_clks(4);
        for (int i = 15; i >= 6; i--) spi_bit(i[0] | (i == 15) ? 1'b1 : 1'b0);
        rst_n = 1'b0;
        wait_clks(3);
        rst_n = 1'b1;
        for (int i = 5; i >= 0; i--) spi_bit(1'b1);
        wait_clks(4);
        ncs = 1'b1;
        wait_clks(6);
        check8("midframe reset uo_out", uo_out, 8'h00);
        check8("midframe reset uio_out", uio_out, 8'h00);

        for (int v = 0; v < 14; v++) begin
            exp_q.push_back('{vecs[v].exp_uo, vecs[v].exp_uio});
            run_frame(vecs[v].rw, vecs[v].addr, vecs[v].data, vecs[v].nbits);
            collect($sformatf("vec%0d", v));
        end

        write_reg(7'h01, 8'h00);
        write_reg(7'h04, 8'h80);
        write_reg(7'h00, 8'h01);
        check8("en bit0 only", uo_out, 8'h01);
        write_reg(7'h02, 8'h01);
        wait_clks(2 * PERIOD);

        wait_level(1'b0, PERIOD + 20, ok);
        check_range("pwm50 low seen", int'(ok), 1, 1);
        wait_level(1'b1, PERIOD + 20, ok);
        check_range("pwm50 rise seen", int'(ok), 1, 1);
        count_level(1'b1, PERIOD + 20, hi);
        count_level(1'b0, PERIOD + 20, lo);
        check_range("pwm50 high clks", hi, HIGH50 - 1, HIGH50 + 1);
        check_range("pwm50 period clks", hi + lo, PERIOD - 1, PERIOD + 1);

        write_reg(7'h04, 8'h00);
        wait_clks(2 * PERIOD + 10);
        count_ones(PERIOD + 20, ones);
        check_range("duty00 high clks", ones, 0, 0);

        write_reg(7'h04, 8'hFF);
        wait_clks(2 * PERIOD + 10);
        count_ones(PERIOD + 20, ones);
        check_range("dutyFF high clks", ones, PERIOD + 20, PERIOD + 20);

`ifdef PWM_SYNC_UPDATE_EN
        write_reg(7'h04, 8'h80);
        wait_clks(2 * PERIOD);
        wait_level(1'b0, PERIOD + 20, ok);
        wait_level(1'b1, PERIOD + 20, ok);
        check_range("sync rise seen", int'(ok), 1, 1);
        wait_clks(300);
        write_reg(7'h04, 8'h00);
        check8("sync old duty held", {7'h0, uo_out[0]}, 8'h01);
        wait_clks(2 * PERIOD);
        count_ones(PERIOD + 20, ones);
        check_range("sync new duty", ones, 0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
